// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: EX/hazard/memory inputs toward the controller and
// the PC, next-PC select, fetch request and IF/ID controls back out.
// master = fetch controller, slave = surrounding pipeline.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              stall;
  logic              imem_ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              pc_src;
  logic              imem_req;
  logic              if_valid;
  logic              flush_if_id;

  modport master (
    input  branch_taken, branch_target, stall, imem_ready,
    output pc, pc_plus4, pc_src, imem_req, if_valid, flush_if_id
  );

  modport slave (
    output branch_taken, branch_target, stall, imem_ready,
    input  pc, pc_plus4, pc_src, imem_req, if_valid, flush_if_id
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and chooses each cycle between
// sequential advance, branch redirect, hazard stall, memory wait and the
// bubble window that follows a redirect.
// Optional feature macro FETCH_PERF_CNT_EN adds saturating fetch_count and
// bubble_count outputs.
module pc_fetch_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                PC_STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  pc_fetch_ctrl_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     bubble_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, FLUSH} state_t;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam logic [3:0]        CNT_INIT   = 4'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_src_q, pc_src_d;
  logic              imem_req_q, imem_req_d;
  logic              if_valid_q, if_valid_d;
  logic              flush_q, flush_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              redirect;

  // Next-state and next-output decision; branch beats stall beats memory wait.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_src_d   = pc_src_q;
    imem_req_d = imem_req_q;
    if_valid_d = if_valid_q;
    flush_d    = 1'b0;
    cnt_d      = cnt_q;
    redirect   = 1'b0;
    case (state_q)
      BOOT: begin
        imem_req_d = 1'b1;
        state_d    = RUN;
      end
      RUN, WAIT_MEM: begin
        if (fif.branch_taken) begin
          redirect = 1'b1;
        end else if (fif.stall) begin
          state_d = state_q;
        end else if (!fif.imem_ready) begin
          if_valid_d = 1'b0;
          state_d    = WAIT_MEM;
        end else begin
          pc_d       = pc_q + STEP;
          if_valid_d = 1'b1;
          pc_src_d   = 1'b0;
          state_d    = RUN;
        end
      end
      FLUSH: begin
        if_valid_d = 1'b0;
        imem_req_d = 1'b0;
        if (fif.branch_taken) begin
          redirect = 1'b1;
        end else if (cnt_q == 4'd0) begin
          imem_req_d = 1'b1;
          pc_src_d   = 1'b0;
          state_d    = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = BOOT;
    endcase
    // A redirect abandons any outstanding fetch and opens a new bubble window.
    if (redirect) begin
      pc_d       = fif.branch_target & ALIGN_MASK;
      pc_src_d   = 1'b1;
      flush_d    = 1'b1;
      if_valid_d = 1'b0;
      imem_req_d = 1'b0;
      cnt_d      = CNT_INIT;
      state_d    = FLUSH;
    end
  end

  // State and registered outputs; reset drops any pending redirect/bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_src_q   <= 1'b0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_src_q   <= pc_src_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fif.pc          = pc_q;
  assign fif.pc_plus4    = pc_q + STEP;
  assign fif.pc_src      = pc_src_q;
  assign fif.imem_req    = imem_req_q;
  assign fif.if_valid    = if_valid_q;
  assign fif.flush_if_id = flush_q;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic advance;
  logic bubble;
  assign advance = ((state_q == RUN) || (state_q == WAIT_MEM)) &&
                   !fif.branch_taken && !fif.stall && fif.imem_ready;
  assign bubble  = (state_q == FLUSH) || (state_q == WAIT_MEM);

  // Saturating counters of completed fetches and bubble cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (advance) fetch_count <= sat_inc(fetch_count);
      if (bubble)  bubble_count <= sat_inc(bubble_count);
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the driver steps a behavioural model
// per clock and queues the expected outputs; a monitor pops and compares.
module tb_pc_fetch_ctrl;
  localparam int          AW = 32;
  localparam int          FC = 3;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pc_fetch_ctrl_if #(.ADDR_W(AW)) fif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  pc_fetch_ctrl #(
    .ADDR_W(AW), .PC_STEP(4), .RESET_VEC(RV), .FLUSH_CYCLES(FC)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .fif(fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        src;
    logic        req;
    logic        vld;
    logic        fl;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Reference model: fetch address, "booting", "waiting for memory" and
  // the number of bubble cycles still to go (-1 when not flushing).
  logic [31:0] m_pc;
  bit          m_boot, m_wait, m_src, m_req, m_vld, m_fl;
  int          m_left;
  logic [31:0] m_fc, m_bc;

  function automatic exp_t snap();
    exp_t e;
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.src = m_src;
    e.req = m_req;
    e.vld = m_vld;
    e.fl  = m_fl;
`ifdef FETCH_PERF_CNT_EN
    e.fc  = m_fc;
    e.bc  = m_bc;
`else
    e.fc  = '0;
    e.bc  = '0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_boot = 1; m_wait = 0; m_left = -1;
    m_src = 0; m_req = 0; m_vld = 0; m_fl = 0;
    m_fc = 0; m_bc = 0;
  endtask

  task automatic model_step(input bit bt, input logic [31:0] tgt,
                            input bit st, input bit rdy);
    bit adv = 0;
    bit bub = (m_left >= 0) || m_wait;
    m_fl = 0;
    if (m_boot) begin
      m_boot = 0;
      m_req  = 1;
    end else if (bt) begin
      m_pc = {tgt[31:2], 2'b00};
      m_src = 1; m_fl = 1; m_vld = 0; m_req = 0;
      m_left = FC - 1; m_wait = 0;
    end else if (m_left >= 0) begin
      if (m_left == 0) begin
        m_left = -1; m_req = 1; m_src = 0;
      end else begin
        m_left--;
      end
    end else if (st) begin
      adv = 0;
    end else if (!rdy) begin
      m_vld = 0; m_wait = 1;
    end else begin
      adv = 1; m_pc = m_pc + 32'd4; m_vld = 1; m_src = 0; m_wait = 0;
    end
    if (adv && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (bub && m_bc != 32'hFFFF_FFFF) m_bc++;
  endtask

  task automatic rst_cyc();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    q.push_back(snap());
  endtask

  task automatic cyc(input bit bt, input logic [31:0] tgt,
                     input bit st, input bit rdy);
    @(negedge clock);
    reset_n            = 1'b1;
    fif.branch_taken  = bt;
    fif.branch_target = tgt;
    fif.stall         = st;
    fif.imem_ready    = rdy;
    model_step(bt, tgt, st, rdy);
    q.push_back(snap());
  endtask

  // Reset asserted mid-cycle: one check right after the async edge, one at
  // the posedge that follows while reset is still held.
  task automatic async_reset();
    @(negedge clock);
    #2;
    model_reset();
    q.push_back(snap());
    q.push_back(snap());
    reset_n = 1'b0;
  endtask

  task automatic rand_cyc();
    cyc($urandom_range(0, 99) < 8, $urandom,
        $urandom_range(0, 99) < 15, $urandom_range(0, 99) >= 20);
  endtask

  // Monitor: compares DUT outputs against the next queued expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clock or negedge reset_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a.pc  = fif.pc;
        a.pc4 = fif.pc_plus4;
        a.src = fif.pc_src;
        a.req = fif.imem_req;
        a.vld = fif.if_valid;
        a.fl  = fif.flush_if_id;
`ifdef FETCH_PERF_CNT_EN
        a.fc  = fetch_count;
        a.bc  = bubble_count;
`else
        a.fc  = '0;
        a.bc  = '0;
`endif
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL vec%0d @%0t: got pc=%h pc4=%h src=%b req=%b vld=%b fl=%b fc=%0d bc=%0d want pc=%h pc4=%h src=%b req=%b vld=%b fl=%b fc=%0d bc=%0d",
                   n_vec, $time, a.pc, a.pc4, a.src, a.req, a.vld, a.fl, a.fc, a.bc,
                   e.pc, e.pc4, e.src, e.req, e.vld, e.fl, e.fc, e.bc);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    fif.branch_taken = 1'b0;
    fif.branch_target = '0;
    fif.stall = 1'b0;
    fif.imem_ready = 1'b0;
    model_reset();
    rst_cyc();
    rst_cyc();

    // Boot, then sequential 0,4,8,C,10
    repeat (5) cyc(0, 0, 0, 1);
    // Redirect to 0x43 -> 0x40, bubbles, then 0x44
    cyc(1, 32'h43, 0, 1);
    repeat (FC + 2) cyc(0, 0, 0, 1);
    // Stall three cycles, then release
    repeat (3) cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // Memory wait two cycles, then ready
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    // Branch while waiting on memory
    cyc(0, 0, 0, 0);
    cyc(1, 32'h200, 0, 0);
    repeat (FC + 1) cyc(0, 0, 0, 1);
    // Branch during stall wins
    cyc(1, 32'h80, 1, 1);
    cyc(0, 0, 1, 1);
    // Back-to-back branches, branch in the middle of a flush
    cyc(1, 32'h100, 0, 1);
    cyc(1, 32'h204, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h308, 1, 0);
    repeat (FC + 2) cyc(0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 1);
    // PC wrap from FFFF_FFFC
    cyc(1, 32'hFFFF_FFFF, 0, 1);
    repeat (FC + 3) cyc(0, 0, 0, 1);
    // Reset mid-flush
    cyc(1, 32'h400, 0, 1);
    cyc(0, 0, 0, 1);
    async_reset();
    repeat (4) cyc(0, 0, 0, 1);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      rand_cyc();
    end

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    #2;
    if (q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences the instruction-fetch stage. Owns the program counter and decides each cycle whether PC advances sequentially, redirects to a branch target, holds for a stall or memory wait, or inserts bubbles after a redirect. Drives the PC-source select for the IF next-PC mux, the instruction-memory request, and the IF/ID valid and flush controls.

Parameters:
ADDR_W, 32, PC and address width
PC_STEP, 4, sequential increment in bytes
RESET_VEC, 32'h0000_0000, PC value after reset
FLUSH_CYCLES, 1, bubble cycles after a redirect (legal range 1..15)

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
branch_taken  input  1  redirect request from EX, sampled at posedge
branch_target  input  ADDR_W  redirect address; bits [1:0] forced to 0 internally
stall  input  1  hazard-unit hold request
imem_ready  input  1  instruction memory can complete the current fetch
pc  output  ADDR_W  current fetch address (registered)
pc_plus4  output  ADDR_W  pc + PC_STEP (combinational, modulo 2^ADDR_W)
pc_src  output  1  0 = sequential, 1 = branch target (registered, for next-PC mux)
imem_req  output  1  fetch request at pc (registered)
if_valid  output  1  IF/ID holds a valid instruction (registered)
flush_if_id  output  1  one-cycle pulse clearing IF/ID (registered)

Behaviour:
- Reset (reset_n low, asynchronous): pc=RESET_VEC, state=BOOT, imem_req=0, if_valid=0, flush_if_id=0, pc_src=0, bubble counter=0. Reset mid-operation discards any pending redirect or bubble count.
- States: BOOT, RUN, WAIT_MEM, FLUSH.
- BOOT: first posedge after reset release -> imem_req<=1, state RUN; pc unchanged.
- Priority each posedge in RUN/WAIT_MEM: branch_taken > stall > !imem_ready > advance.
- Redirect (branch_taken=1 in RUN, WAIT_MEM or FLUSH): pc<={branch_target[ADDR_W-1:2],2'b00}, pc_src<=1, flush_if_id<=1 for exactly one cycle, if_valid<=0, imem_req<=0, counter<=FLUSH_CYCLES-1, state FLUSH. Outstanding fetch abandoned. Branch during stall wins over stall.
- Stall (RUN or WAIT_MEM, no branch): pc, pc_src, if_valid held; no state change.
- RUN, !imem_ready: pc held, if_valid<=0, state WAIT_MEM.
- RUN, imem_ready, no stall: pc<=pc+PC_STEP (wraps FFFF_FFFC->0000_0000 for ADDR_W=32), if_valid<=1, pc_src<=0.
- WAIT_MEM: imem_ready & !stall -> advance as RUN, state RUN; else hold, if_valid=0.
- FLUSH: if_valid=0, imem_req=0; counter==0 -> imem_req<=1, pc_src<=0, state RUN; else counter decrements. New branch_taken restarts FLUSH with new target. stall ignored in FLUSH.
- flush_if_id never asserted two consecutive cycles unless branch_taken asserted two consecutive cycles.
- Latency: redirect to first fetch at target = FLUSH_CYCLES+1 posedges.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs fetch_count[31:0] (increments on every advance) and bubble_count[31:0] (increments each cycle in FLUSH or WAIT_MEM); both reset to 0, saturate at FFFF_FFFF. When undefined, ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ready=1, no stall -> BOOT one cycle, then pc 0,4,8,C on successive cycles, if_valid=1 from first advance, pc_src=0.
- At pc=0x10, branch_taken=1, target=0x43 -> next pc=0x40, pc_src=1, flush_if_id pulse 1 cycle, if_valid=0 for FLUSH_CYCLES+1 cycles, then pc 0x44.
- stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20, if_valid unchanged; stall drop -> pc=0x24.
- imem_ready=0 for 2 cycles at pc=0x8 -> WAIT_MEM, if_valid=0, pc=0x8; ready -> pc=0xC; branch during WAIT_MEM -> redirect taken immediately.
- pc=0xFFFF_FFFC, advance -> pc=0x0000_0000, pc_plus4=0x4.
- Assert reset_n low mid-FLUSH -> all outputs to reset values asynchronously, pc=RESET_VEC; with FETCH_PERF_CNT_EN, counters return to 0.
